// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU,
//               DIV/DIVU/REM/REMU, optional RV64 word forms). One bit per
//               cycle shift-add multiply and restoring divide, with a
//               one-cycle fast path for divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv #(
  parameter int XLEN      = 32,
  parameter int SUPPORT_W = 0,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       md_op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int                c_cnt_w   = $clog2(XLEN);
  localparam logic [XLEN-1:0]   c_low32   = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0]   c_min32   = XLEN'(32'h8000_0000);
  localparam logic [XLEN-1:0]   c_minx    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [c_cnt_w-1:0] c_last32 = c_cnt_w'(31);
  localparam logic [c_cnt_w-1:0] c_lastx  = c_cnt_w'(XLEN-1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Word results are the low 32 bits sign-extended to the full width.
  function automatic logic [XLEN-1:0] f_fit(input logic [XLEN-1:0] v, input logic word);
    if (word) f_fit = (v & c_low32) | ({XLEN{v[31]}} & ~c_low32);
    else      f_fit = v;
  endfunction

  // ---------------- operand decode and preparation ----------------
  logic            w_word, w_is_div, w_is_rem, w_hi;
  logic            w_s1, w_s2, w_neg1, w_neg2, w_neg_res;
  logic [XLEN-1:0] w_mask, w_op1, w_op2, w_mag1, w_mag2;
  logic            w_div_zero, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0] w_fast_val, w_fast_res;
  logic            w_unused_op;

  assign w_word   = (SUPPORT_W != 0) && word_i;
  assign w_mask   = w_word ? c_low32 : {XLEN{1'b1}};
  assign w_is_div = |md_op_i[7:4];
  assign w_is_rem = md_op_i[6] | md_op_i[7];
  // High-half multiplies degrade to a plain low-half multiply in word mode.
  assign w_hi     = (|md_op_i[3:1]) & ~w_word;
  // Plain mul is what remains when no other bit is set.
  assign w_unused_op = md_op_i[0];

  assign w_s1 = md_op_i[1] | md_op_i[2] | md_op_i[4] | md_op_i[6];
  assign w_s2 = md_op_i[1] | md_op_i[4] | md_op_i[6];

  assign w_neg1 = w_s1 & (w_word ? rs1_data_i[31] : rs1_data_i[XLEN-1]);
  assign w_neg2 = w_s2 & (w_word ? rs2_data_i[31] : rs2_data_i[XLEN-1]);

  assign w_op1  = rs1_data_i & w_mask;
  assign w_op2  = rs2_data_i & w_mask;
  assign w_mag1 = w_neg1 ? ((-rs1_data_i) & w_mask) : w_op1;
  assign w_mag2 = w_neg2 ? ((-rs2_data_i) & w_mask) : w_op2;

  // Remainder follows the dividend's sign; product and quotient the xor.
  assign w_neg_res = w_is_rem ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div_zero = (w_op2 == '0);
  assign w_ovf      = (md_op_i[4] | md_op_i[6]) &
                      (w_op1 == (w_word ? c_min32 : c_minx)) &
                      (w_op2 == w_mask);
  assign w_fast     = w_is_div & (w_div_zero | w_ovf);
  assign w_fast_val = w_div_zero ? (w_is_rem ? w_op1 : w_mask)
                                 : (w_is_rem ? '0 : w_op1);
  assign w_fast_res = f_fit(w_fast_val, w_word);

  assign w_accept = (r_state == S_IDLE) & in_valid_i & ~flush_i;

  // ---------------- iteration datapath ----------------
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_a, r_b, r_q, r_result;
  logic [c_cnt_w-1:0] r_cnt;
  logic              r_div, r_rem, r_hi, r_wd, r_neg;
  logic [TAG_W-1:0]  r_tag;

  logic              w_bit_a, w_bit_b, w_fits;
  logic [2*XLEN-1:0] w_prod_nxt, w_acc_nxt, w_prod_signed;
  logic [XLEN:0]     w_rem_sh, w_rem_diff;
  logic [XLEN-1:0]   w_rem_nxt, w_q_nxt, w_q_signed, w_rem_signed, w_raw, w_final;

  assign w_bit_a = r_a[r_cnt];
  assign w_bit_b = r_b[r_cnt];

  // Multiply: walk the multiplier MSB first, shift the partial product left.
  assign w_prod_nxt = (r_acc << 1) + (w_bit_b ? {{XLEN{1'b0}}, r_a} : '0);

  // Divide: bring down one dividend bit, subtract if the divisor fits.
  assign w_rem_sh   = {r_acc[XLEN-1:0], w_bit_a};
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_fits     = ~w_rem_diff[XLEN];
  assign w_rem_nxt  = w_fits ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_q_nxt    = (r_q << 1) | XLEN'(w_fits);

  assign w_acc_nxt  = r_div ? {{XLEN{1'b0}}, w_rem_nxt} : w_prod_nxt;

  assign w_prod_signed = r_neg ? -w_prod_nxt : w_prod_nxt;
  assign w_q_signed    = r_neg ? -w_q_nxt   : w_q_nxt;
  assign w_rem_signed  = r_neg ? -w_rem_nxt : w_rem_nxt;

  assign w_raw   = r_div ? (r_rem ? w_rem_signed : w_q_signed)
                         : (r_hi ? w_prod_signed[2*XLEN-1:XLEN] : w_prod_signed[XLEN-1:0]);
  assign w_final = f_fit(w_raw, r_wd);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (w_accept) w_state_nxt = w_fast ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  // Operand capture at accept, then one multiply/divide step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_rem    <= 1'b0;
      r_hi     <= 1'b0;
      r_wd     <= 1'b0;
      r_neg    <= 1'b0;
      r_tag    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a   <= w_mag1;
      r_b   <= w_mag2;
      r_acc <= '0;
      r_q   <= '0;
      r_cnt <= w_word ? c_last32 : c_lastx;
      r_div <= w_is_div;
      r_rem <= w_is_rem;
      r_hi  <= w_hi;
      r_wd  <= w_word;
      r_neg <= w_neg_res;
      r_tag <= tag_i;
      if (w_fast) r_result <= w_fast_res;
    end else if ((r_state == S_BUSY) && !flush_i) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_one;
      else             r_result <= w_final;
    end
  end

  assign result_o = r_result;
  assign tag_o    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv
// Description : Directed vector bench for execute_muldiv: an XLEN=32 instance
//               for the main op table and corner sequences, and an XLEN=64
//               word-capable instance for the W forms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv32, iv64;
  logic [7:0]  md_op;
  logic        word;
  logic [63:0] rs1, rs2;
  logic [4:0]  tag;
  logic        flush, out_ready;

  logic        ir32, ov32, busy32;
  logic [31:0] res32;
  logic [4:0]  tag32;
  logic        ir64, ov64, busy64;
  logic [63:0] res64;
  logic [4:0]  tag64;

  logic        sel64;
  logic        m_valid, m_ready;
  logic [63:0] m_result;
  logic [4:0]  m_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .SUPPORT_W(0), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv32), .in_ready_o(ir32),
    .md_op_i(md_op), .word_i(word), .rs1_data_i(rs1[31:0]), .rs2_data_i(rs2[31:0]),
    .tag_i(tag), .flush_i(flush), .out_valid_o(ov32), .out_ready_i(out_ready),
    .result_o(res32), .tag_o(tag32), .busy_o(busy32)
  );

  execute_muldiv #(.XLEN(64), .SUPPORT_W(1), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv64), .in_ready_o(ir64),
    .md_op_i(md_op), .word_i(word), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .tag_i(tag), .flush_i(flush), .out_valid_o(ov64), .out_ready_i(out_ready),
    .result_o(res64), .tag_o(tag64), .busy_o(busy64)
  );

  assign m_valid  = sel64 ? ov64  : ov32;
  assign m_ready  = sel64 ? ir64  : ir32;
  assign m_result = sel64 ? res64 : {32'b0, res32};
  assign m_tag    = sel64 ? tag64 : tag32;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op, count edges to out_valid, check result/tag, then release it.
  task automatic run_op(input bit wide, input string name, input logic [7:0] op,
                        input bit w, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] t, input logic [63:0] exp, input int exp_lat);
    int edges;
    sel64 = wide;
    @(negedge clk);
    md_op = op; word = w; rs1 = a; rs2 = b; tag = t; out_ready = 1'b0;
    if (wide) iv64 = 1'b1; else iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    edges = 1;
    while (!m_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({name, " valid"},   {63'b0, m_valid}, 64'd1);
    chk({name, " latency"}, 64'(edges), 64'(exp_lat));
    chk({name, " result"},  m_result, exp);
    chk({name, " tag"},     {59'b0, m_tag}, {59'b0, t});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({name, " release"}, {62'b0, m_valid, m_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;
    bit seen;
    vecs[0]  = '{"mul 7*-3",        8'h01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"mulh min*min",    8'h02, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{"mulhu ff*ff",     8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{"mulhsu -1*2",     8'h04, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div -7/2",        8'h10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem -7/2",        8'h40, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu 100/7",      8'h20, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{"remu 100/7",      8'h80, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{"div 5/0",         8'h10, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"rem 5/0",         8'h40, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{"div ovf",         8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"rem ovf",         8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{"divu 5/0",        8'h20, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{"remu x/0",        8'h80, 32'h1234_5678, 32'd0,         32'h1234_5678, 1};
    vecs[14] = '{"mul x*16",        8'h01, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
    vecs[15] = '{"mulhu x*16",      8'h08, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 33};
    vecs[16] = '{"div 7/-2",        8'h10, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[17] = '{"rem 7/-2",        8'h40, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};

    rst_n = 1'b0; iv32 = 1'b0; iv64 = 1'b0; md_op = 8'h00; word = 1'b0;
    rs1 = '0; rs2 = '0; tag = '0; flush = 1'b0; out_ready = 1'b0; sel64 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset 32 outputs", {59'b0, ov32, ir32, busy32, 2'b0}, {59'b0, 1'b0, 1'b1, 1'b0, 2'b0});
    chk("reset 32 result",  {32'b0, res32}, 64'd0);
    chk("reset 32 tag",     {59'b0, tag32}, 64'd0);
    chk("reset 64 outputs", {61'b0, ov64, ir64, busy64}, {61'b0, 3'b010});
    chk("reset 64 result",  res64, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      run_op(1'b0, vecs[i].name, vecs[i].op, 1'b0, {32'b0, vecs[i].a}, {32'b0, vecs[i].b},
             5'(i + 3), {32'b0, vecs[i].exp}, vecs[i].lat);

    // Backpressure: result held in DONE, no accept while waiting.
    sel64 = 1'b0;
    @(negedge clk);
    md_op = 8'h20; rs1 = 64'd100; rs2 = 64'd7; tag = 5'd21; iv32 = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; iv32 = 1'b0;
    edges = 1;
    while (!ov32 && edges < 100) begin @(posedge clk); #1; edges++; end
    chk("bp latency", 64'(edges), 64'd33);
    for (int c = 0; c < 5; c++) begin
      iv32 = 1'b1;
      @(posedge clk); #1;
      chk("bp hold state", {61'b0, ov32, ir32, busy32}, {61'b0, 3'b101});
      chk("bp hold result", {32'b0, res32}, 64'd14);
    end
    iv32 = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp release", {61'b0, ov32, ir32, busy32}, {61'b0, 3'b010});

    // Flush at BUSY count 10: back to IDLE, no result ever appears.
    @(negedge clk);
    md_op = 8'h01; rs1 = 64'd9; rs2 = 64'd9; tag = 5'd7; iv32 = 1'b1;
    @(posedge clk); #1; iv32 = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("flush pre busy", {63'b0, busy32}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush idle", {61'b0, ov32, ir32, busy32}, {61'b0, 3'b010});
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ov32) seen = 1'b1;
    end
    chk("flush no result", {63'b0, seen}, 64'd0);

    // Flush together with in_valid in IDLE: nothing accepted.
    @(negedge clk);
    md_op = 8'h20; rs1 = 64'd50; rs2 = 64'd5; iv32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1; iv32 = 1'b0; flush = 1'b0;
    chk("flush blocks accept", {61'b0, ov32, ir32, busy32}, {61'b0, 3'b010});

    // Asynchronous reset mid-BUSY: outputs return to reset values at once.
    @(negedge clk);
    md_op = 8'h20; rs1 = 64'd1000; rs2 = 64'd3; tag = 5'd30; iv32 = 1'b1;
    @(posedge clk); #1; iv32 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("rst pre busy", {63'b0, busy32}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async state", {61'b0, ov32, ir32, busy32}, {61'b0, 3'b010});
    chk("rst async result", {32'b0, res32}, 64'd0);
    chk("rst async tag", {59'b0, tag32}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // RV64 word forms and the full-width comparison.
    run_op(1'b1, "divw -7/2", 8'h10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
           5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op(1'b1, "div64 same", 8'h10, 1'b0, 64'h0000_0000_FFFF_FFF9, 64'd2,
           5'd12, 64'h0000_0000_7FFF_FFFC, 65);
    run_op(1'b1, "mulh as mulw", 8'h02, 1'b1, 64'd7, 64'h0000_0000_FFFF_FFFD,
           5'd13, 64'hFFFF_FFFF_FFFF_FFEB, 33);
    run_op(1'b1, "remw x/0", 8'h40, 1'b1, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000,
           5'd14, 64'hFFFF_FFFF_8000_0005, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Multi-cycle RV M-extension unit that sits beside the single-cycle integer execute stage.
- Takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with already-forwarded operands.
- Iterates one bit per cycle and returns the result through a valid/ready handshake.
- Parametrised in XLEN. Supports RV64 word (W) ops. Has a fast path for division special cases and a pipeline-flush input.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SUPPORT_W, 0, 1 enables word ops; only legal with XLEN=64.
- TAG_W, 5, width of the opaque tag (rd index) carried with each op.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  op presented.
- in_ready_o  out  1  unit can accept.
- md_op_i  in  8  one-hot op; bits 0..7 = mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- word_i  in  1  W op (ignored when SUPPORT_W=0).
- rs1_data_i  in  XLEN  operand 1 (multiplicand / dividend).
- rs2_data_i  in  XLEN  operand 2 (multiplier / divisor).
- tag_i  in  TAG_W  tag.
- flush_i  in  1  kill any in-flight op.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes result.
- result_o  out  XLEN  result.
- tag_o  out  TAG_W  tag of the result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid_o=0, result_o=0, tag_o=0, busy_o=0, in_ready_o=1; counter, accumulator and operand registers cleared.
- States:
  - IDLE: in_ready_o=1. Accept when in_valid_i & ~flush_i. Go to DONE if the op is a fast-path op, otherwise to BUSY.
  - BUSY: in_ready_o=0. One iteration per cycle; counter runs N-1 down to 0. After the iteration at count 0, go to DONE.
  - DONE: out_valid_o=1; result_o and tag_o held stable. When out_ready_i=1, go to IDLE. There is no accept in the same cycle.
- N = 32 when word_i & SUPPORT_W, else XLEN.
- Normal latency: accept edge → out_valid_o high after exactly N+1 rising edges.
- Fast path (out_valid_o after 1 edge):
  - Divisor = 0: div/divu give all ones; rem/remu give the dividend.
  - Signed overflow (dividend = most-negative N-bit, divisor = −1): div gives the dividend; rem gives 0.
- Operand preparation:
  - Word ops take the low 32 bits, sign- or zero-extended per op signedness.
  - Signed operands are converted to magnitudes; sign flags are latched at accept.
  - mulhsu treats rs1 as signed and rs2 as unsigned.
- Multiply: unsigned shift-add over N iterations into a 2N-bit product.
  - Negate the product if sign1^sign2.
  - mul returns the low N bits; mulh* return the high N bits.
  - word_i with any mulh* is executed as MULW.
- Divide: restoring, one quotient bit per iteration.
  - Quotient sign = s1^s2; remainder sign = s1.
  - Remainder magnitude is always less than |divisor|.
- Word result: the 32-bit result is sign-extended to XLEN.
- Flush: synchronous, highest priority.
  - Any state goes to IDLE on the next edge and out_valid_o drops.
  - An in_valid_i in the same cycle is not accepted.
  - A flush in DONE with out_ready_i=1 discards the result; the consumer must ignore it.
- Backpressure: DONE is held indefinitely while out_ready_i=0. No result is lost or overwritten.
- Reset asserted mid-operation: immediate return to reset values, independent of clk.

Test Plan:
- XLEN=32, mul 7 × 0xFFFFFFFD → result 0xFFFFFFEB. out_valid_o rises exactly 33 edges after accept; tag echoed.
- High-half multiplies:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- Divide/remainder:
  - div 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - rem 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - divu 100/7 → 14; remu 100/7 → 2.
  - All with 33-edge latency.
- Special cases, each with out_valid_o one edge after accept:
  - div 5/0 → 0xFFFFFFFF; rem 5/0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem of the same → 0.
- Backpressure, flush and reset:
  - Hold out_ready_i=0 for 5 cycles in DONE → result_o stable, in_ready_o=0. Raise out_ready_i → IDLE next edge.
  - flush_i at BUSY count 10 → no out_valid_o, in_ready_o=1 next edge.
  - rst_n pulsed low mid-BUSY → all outputs at reset values immediately.
- XLEN=64, SUPPORT_W=1: divw 0x00000000FFFFFFF9 / 2 → 0xFFFFFFFFFFFFFFFD after 33 edges. The same operands as a full div take 65 edges.
